acc_buffer_ctrl: RTL
====================

Name: acc_buffer_ctrl

Overview:
- Accumulator buffer on the responder side of the systolic controller's accumulator interface.
- Accepts per-column result writes in two modes, overwrite or accumulate, as a read-modify-write through a 2-stage pipeline with same-address bypass.
- Runs the sequential accumulator clear and reports it on acc_clear_busy / acc_clear_complete.
- Provides a synchronous readback port for the unified-buffer drain path.

Parameters:
ACC_W, 32, width of one accumulator lane (two's complement)
DEPTH, 256, number of entries; address width is 8 (fixed by interface)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
acc_wr_en  in  1  write request this cycle
acc_wr_addr  in  8  write address
acc_wr_col01  in  1  lane0<=acc0_in, lane1<=acc1_in
acc_wr_col2  in  1  lane0<=acc2_in, lane1 preserved
acc_accumulate  in  1  1=add to stored value, 0=overwrite
acc0_in, acc1_in, acc2_in  in  ACC_W each  column results
acc_clear  in  1  clear request (level)
acc_clear_busy  out  1  sequential clear in progress
acc_clear_complete  out  1  one-cycle pulse at end of clear
rd_en  in  1  readback request
rd_addr  in  8  readback address
rd_data  out  2*ACC_W  {lane1, lane0}
rd_valid  out  1  rd_data valid
err_clr  in  1  clears sticky error flags
wr_drop_err  out  1  sticky: write dropped (during clear, or no lane select)
sel_conflict_err  out  1  sticky: col01 and col2 both set

Behaviour:
- Reset values: all outputs 0. FSM IDLE, armed=1, pipeline empty. Memory contents are undefined until the first clear.
- FSM states: IDLE, CLEAR, DONE.
- IDLE->CLEAR when acc_clear=1, armed=1, and pipeline stage S1 is empty; otherwise the request waits.
- Entering CLEAR sets armed=0. armed returns to 1 on any cycle acc_clear=0.
- Clear timing: acc_clear sampled in cycle T; cycles T+1..T+DEPTH write zero to addresses 0..DEPTH-1. acc_clear_busy is registered and high exactly in those DEPTH cycles.
- DONE occupies cycle T+DEPTH+1: acc_clear_complete=1, busy=0. Next state is IDLE.
- acc_clear still high after DONE does not retrigger, because armed=0.
- acc_wr_en while in CLEAR or DONE: write dropped, wr_drop_err set.
- Write pipeline, request at cycle T:
  - S0 (T): issue internal read of addr. Latch addr, lanes, mode and data.
  - S1 (T+1): form new entry and commit at the edge ending T+1.
- Write throughput is one per cycle.
- New-entry arithmetic, modulo 2^ACC_W, no saturation:
  - overwrite col01: {acc1, acc0}
  - overwrite col2: {old1, acc2}
  - accumulate col01: {old1+acc1, old0+acc0}
  - accumulate col2: {old1, old0+acc2}
- Bypass: S1's "old" value comes from the last-commit register when the last commit's addr equals the S1 addr; otherwise it comes from the memory read. This handles back-to-back same-address writes.
- Both col01 and col2 set: col01 wins, sel_conflict_err set.
- acc_wr_en with neither select: write dropped, wr_drop_err set.
- Readback: rd_en in cycle T gives rd_data and rd_valid=1 in T+1. rd_valid stays 0 when rd_en=0, and rd_data holds its last value.
- Read/write collision: a read of the address committed in the same cycle returns the pre-write value (read-first).
- Reads are not blocked during CLEAR and return current contents.
- err_clr clears both sticky flags. An error event in the same cycle takes priority and the flag stays set.
- Reset mid-operation: the clear aborts with no complete pulse, in-flight writes are lost, armed=1. The next clear restarts at address 0.

Decomposition:
- Package tpu_acc_pkg holds: ACC_W, ACC_DEPTH, ACC_ADDR_W=8, and enum acc_buf_state_t {ACC_IDLE, ACC_CLEAR, ACC_DONE}.
- Sub-module acc_dual_read_ram: DEPTH x 2*ACC_W array with one write port and two synchronous read-first read ports (internal RMW, external readback), no reset on the array.

Test Plan:
- Reset, then hold acc_clear=1 until complete: busy high exactly 256 cycles, complete pulses once at T+257, no retrigger while acc_clear stays high; reads of addr 0/128/255 return 0.
- After clear, overwrite col01 addr 5 (acc0=3, acc1=-4), then col2 addr 6 (acc2=7): rd addr5 = {0xFFFFFFFC, 0x00000003}, addr6 = {0, 7}, rd_valid one cycle after rd_en.
- Accumulate col01 addr 10 with acc0=1, acc1=2 on three consecutive cycles: addr10 = {6, 3}, which exercises the bypass.
- Accumulate col01 addr 20: lane0 0x7FFFFFFF + 1 gives 0x80000000, no error flag.
- acc_wr_en during CLEAR at addr 50 with acc0=9: write dropped, wr_drop_err=1, addr50 reads 0 after complete; err_clr returns the flag to 0.
- Assert rst_n=0 at clear cycle 100: busy=0, no complete pulse; a new acc_clear runs the full 256 cycles and zeroes addr 0.

Source files
------------

// File: rtl/acc_buffer_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// tpu_acc_pkg
// Shared constants and types for the accumulator buffer.
//   ACC_W          width of one accumulator lane (two's complement)
//   ACC_DEPTH      number of accumulator entries
//   ACC_ADDR_W     address width of the accumulator interface
//   acc_buf_state_t  clear sequencer states
// ----------------------------------------------------------------------------
package tpu_acc_pkg;

    localparam int ACC_W      = 32;
    localparam int ACC_DEPTH  = 256;
    localparam int ACC_ADDR_W = 8;

    typedef enum logic [1:0] {
        ACC_IDLE  = 2'd0,
        ACC_CLEAR = 2'd1,
        ACC_DONE  = 2'd2
    } acc_buf_state_t;

endpackage

// File: rtl/acc_dual_read_ram.sv
// ----------------------------------------------------------------------------
// acc_dual_read_ram
// DEPTH x DATA_W storage with one write port and two synchronous read ports.
// Both read ports are read-first: a read of the address being written on the
// same edge returns the old contents.
//   clk, rst_n        clock, async active-low reset (read registers only)
//   we, waddr, wdata  write port
//   re_a, raddr_a     read port A request (internal read-modify-write)
//   rdata_a           read port A data, valid the cycle after re_a
//   re_b, raddr_b     read port B request (external readback)
//   rdata_b           read port B data, holds when re_b is low
// ----------------------------------------------------------------------------
module acc_dual_read_ram #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto RAM macros; its contents
    // are defined only by the sequential clear.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Non-blocking reads sample the array before the write above lands,
    // which is what makes both ports read-first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            if (re_a) begin
                rdata_a <= mem[raddr_a];
            end
            if (re_b) begin
                rdata_b <= mem[raddr_b];
            end
        end
    end

endmodule

// File: rtl/acc_buffer_ctrl.sv
// ----------------------------------------------------------------------------
// acc_buffer_ctrl
// Accumulator buffer on the responder side of the accumulator interface.
// Column results are written as overwrite or accumulate through a 2-stage
// read-modify-write pipeline (S0 read, S1 combine + commit) with a bypass
// from the last commit for back-to-back same-address writes. A sequential
// clear zeroes every entry, and a synchronous readback port serves the
// unified-buffer drain path.
//   clk, rst_n                       clock, async active-low reset
//   acc_wr_en, acc_wr_addr           write request and address
//   acc_wr_col01                     lane0<=acc0_in, lane1<=acc1_in
//   acc_wr_col2                      lane0<=acc2_in, lane1 preserved
//   acc_accumulate                   1 = add to stored value, 0 = overwrite
//   acc0_in, acc1_in, acc2_in        column results
//   acc_clear                        clear request (level)
//   acc_clear_busy                   high while entries are being zeroed
//   acc_clear_complete               one-cycle pulse after the last entry
//   rd_en, rd_addr                   readback request
//   rd_data, rd_valid                {lane1, lane0} one cycle after rd_en
//   err_clr                          clears the sticky error flags
//   wr_drop_err                      sticky: a write was dropped
//   sel_conflict_err                 sticky: both lane selects were set
// ----------------------------------------------------------------------------
module acc_buffer_ctrl
    import tpu_acc_pkg::*;
#(
    parameter int ACC_W = tpu_acc_pkg::ACC_W,
    parameter int DEPTH = ACC_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  acc_wr_en,
    input  logic [ACC_ADDR_W-1:0] acc_wr_addr,
    input  logic                  acc_wr_col01,
    input  logic                  acc_wr_col2,
    input  logic                  acc_accumulate,
    input  logic [ACC_W-1:0]      acc0_in,
    input  logic [ACC_W-1:0]      acc1_in,
    input  logic [ACC_W-1:0]      acc2_in,
    input  logic                  acc_clear,
    output logic                  acc_clear_busy,
    output logic                  acc_clear_complete,
    input  logic                  rd_en,
    input  logic [ACC_ADDR_W-1:0] rd_addr,
    output logic [2*ACC_W-1:0]    rd_data,
    output logic                  rd_valid,
    input  logic                  err_clr,
    output logic                  wr_drop_err,
    output logic                  sel_conflict_err
);

    localparam int AW = ACC_ADDR_W;
    localparam int DW = 2 * ACC_W;

    acc_buf_state_t state;
    logic           armed;
    logic [AW-1:0]  clr_addr;

    // S1 stage registers
    logic           s1_valid;
    logic [AW-1:0]  s1_addr;
    logic           s1_col01;
    logic           s1_accum;
    logic [ACC_W-1:0] s1_d0;
    logic [ACC_W-1:0] s1_d1;

    // Last commit, used as the bypass source
    logic           lc_valid;
    logic [AW-1:0]  lc_addr;
    logic [DW-1:0]  lc_data;

    logic           clear_start;
    logic           clearing;
    logic           wr_accept;
    logic           wr_drop;
    logic           sel_conflict;
    logic           commit;

    logic [DW-1:0]  ram_rdata_a;
    logic           ram_we;
    logic [AW-1:0]  ram_waddr;
    logic [DW-1:0]  ram_wdata;

    logic [DW-1:0]    old_entry;
    logic [DW-1:0]    new_entry;
    logic [ACC_W-1:0] new0;
    logic [ACC_W-1:0] new1;

    // The clear waits for S1 to drain so no commit competes with the
    // clear for the write port.
    assign clear_start = (state == ACC_IDLE) && acc_clear && armed && !s1_valid;
    assign clearing    = (state == ACC_CLEAR);

    // A write coinciding with the clear launch is dropped as well: it would
    // commit in the first clear cycle, where the clear owns the write port.
    assign wr_accept    = acc_wr_en && (acc_wr_col01 || acc_wr_col2)
                          && (state == ACC_IDLE) && !clear_start;
    assign wr_drop      = acc_wr_en && !wr_accept;
    assign sel_conflict = acc_wr_en && acc_wr_col01 && acc_wr_col2;

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    // NOTE: all sequential state uses non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= ACC_IDLE;
            armed              <= 1'b1;
            clr_addr           <= '0;
            acc_clear_busy     <= 1'b0;
            acc_clear_complete <= 1'b0;
        end else begin
            acc_clear_complete <= 1'b0;
            if (!acc_clear) begin
                armed <= 1'b1;
            end
            case (state)
                ACC_IDLE: begin
                    if (clear_start) begin
                        state          <= ACC_CLEAR;
                        armed          <= 1'b0;
                        clr_addr       <= '0;
                        acc_clear_busy <= 1'b1;
                    end
                end
                ACC_CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == AW'(DEPTH - 1)) begin
                        state              <= ACC_DONE;
                        acc_clear_busy     <= 1'b0;
                        acc_clear_complete <= 1'b1;
                    end
                end
                ACC_DONE: begin
                    state <= ACC_IDLE;
                end
                default: begin
                    state <= ACC_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // S0 -> S1: latch the request while the RAM reads the old entry
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_col01 <= 1'b0;
            s1_accum <= 1'b0;
            s1_d0    <= '0;
            s1_d1    <= '0;
        end else begin
            s1_valid <= wr_accept;
            if (wr_accept) begin
                s1_addr  <= acc_wr_addr;
                s1_col01 <= acc_wr_col01;
                s1_accum <= acc_accumulate;
                // col01 wins when both selects are set
                s1_d0    <= acc_wr_col01 ? acc0_in : acc2_in;
                s1_d1    <= acc1_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // S1: form the new entry
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        old_entry = ram_rdata_a;
        // The RAM read for this write sampled the array on the same edge the
        // previous write committed, so it missed that commit.
        if (lc_valid && (lc_addr == s1_addr)) begin
            old_entry = lc_data;
        end
        new0 = s1_accum ? old_entry[ACC_W-1:0] + s1_d0 : s1_d0;
        new1 = old_entry[DW-1:ACC_W];
        if (s1_col01) begin
            new1 = s1_accum ? old_entry[DW-1:ACC_W] + s1_d1 : s1_d1;
        end
        new_entry = {new1, new0};
    end

    // The clear owns the write port while it runs.
    assign ram_we    = clearing || s1_valid;
    assign ram_waddr = clearing ? clr_addr : s1_addr;
    assign ram_wdata = clearing ? '0 : new_entry;
    assign commit    = s1_valid && !clearing;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lc_valid <= 1'b0;
            lc_addr  <= '0;
            lc_data  <= '0;
        end else if (commit) begin
            lc_valid <= 1'b1;
            lc_addr  <= s1_addr;
            lc_data  <= new_entry;
        end else if (clearing) begin
            // The held value is stale once its entry has been zeroed.
            lc_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Readback valid and sticky errors (a new event beats err_clr)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid         <= 1'b0;
            wr_drop_err      <= 1'b0;
            sel_conflict_err <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (wr_drop) begin
                wr_drop_err <= 1'b1;
            end else if (err_clr) begin
                wr_drop_err <= 1'b0;
            end
            if (sel_conflict) begin
                sel_conflict_err <= 1'b1;
            end else if (err_clr) begin
                sel_conflict_err <= 1'b0;
            end
        end
    end

    acc_dual_read_ram #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .ADDR_W (AW)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (ram_we),
        .waddr   (ram_waddr),
        .wdata   (ram_wdata),
        .re_a    (wr_accept),
        .raddr_a (acc_wr_addr),
        .rdata_a (ram_rdata_a),
        .re_b    (rd_en),
        .raddr_b (rd_addr),
        .rdata_b (rd_data)
    );

endmodule
